// File: rtl/switch_sched.sv
// rtl/switch_sched.sv - NoC router control: round-robin queue write grant and XY-routing read FSM
// Optional feature macro: SWITCH_SCHED_TIMEOUT_EN (R_SEND stall timeout that drops the head flit)
module switch_sched #(
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4,
  parameter int NODES_NUM = 9,
  parameter int MESH_X    = 3,
  parameter int ADDR      = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic [PORTS_NUM:0]   req_i,
  output logic [PORTS_NUM:0]   ack_o,
  input  logic [PORTS_NUM:0]   rdy_i,
  output logic [PORTS_NUM:0]   vld_o,
  input  logic                 mem_full,
  input  logic                 mem_empty,
  input  logic [ADDR_SIZE-1:0] head_addr,
  output logic                 wr_req,
  output logic                 mem_readed,
  output logic [31:0]          in_port,
  output logic [31:0]          out_port,
  output logic                 err_o
);
  localparam int NP = PORTS_NUM + 1;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int AX = ADDR % MESH_X;
  localparam int AY = ADDR / MESH_X;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ROUTE = 2'd1;
  localparam logic [1:0] R_SEND  = 2'd2;

  localparam logic [PW-1:0] P_N = PW'(0);
  localparam logic [PW-1:0] P_E = PW'(1);
  localparam logic [PW-1:0] P_S = PW'(2);
  localparam logic [PW-1:0] P_W = PW'(3);
  localparam logic [PW-1:0] P_L = PW'(PORTS_NUM);

  localparam logic [PORTS_NUM:0] ONE_HOT0 = {{PORTS_NUM{1'b0}}, 1'b1};

  logic [PW-1:0]  rr_ptr_q, rr_ptr_d, grant_idx;
  logic           grant_found;
  logic [1:0]     state_q, state_d;
  logic [PW-1:0]  port_q, port_d, route_port;
  logic           err_q, err_d;
  logic           addr_bad;
  logic           pop;
  logic [PORTS_NUM:0] vld;

`ifdef SWITCH_SCHED_TIMEOUT_EN
  logic [15:0]    tmo_q, tmo_d;
`else
  logic           unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Round-robin search: first requester at or after rr_ptr, wrapping around the ring
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NP; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % NP);
      if (!grant_found && req_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign wr_req   = grant_found & ~mem_full & ~a_rst;
  assign ack_o    = wr_req ? (ONE_HOT0 << grant_idx) : '0;
  assign in_port  = 32'(grant_idx);
  assign rr_ptr_d = wr_req ? PW'((int'(grant_idx) + 1) % NP) : rr_ptr_q;

  // XY routing of the head flit: resolve X first, then Y, else deliver locally
  always_comb begin
    int hx, hy;
    hx = int'(head_addr) % MESH_X;
    hy = int'(head_addr) / MESH_X;
    if (hx > AX)      route_port = P_E;
    else if (hx < AX) route_port = P_W;
    else if (hy > AY) route_port = P_S;
    else if (hy < AY) route_port = P_N;
    else              route_port = P_L;
  end

  assign addr_bad = (int'(head_addr) >= NODES_NUM);

  // Read FSM next state: idle -> route (latch port or drop bad flit) -> send with handshake
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    err_d   = err_q;
    pop     = 1'b0;
    vld     = '0;
`ifdef SWITCH_SCHED_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      R_IDLE: begin
        if (!mem_empty) state_d = R_ROUTE;
      end
      R_ROUTE: begin
        if (addr_bad) begin
          pop     = 1'b1;
          err_d   = 1'b1;
          state_d = R_IDLE;
        end else begin
          port_d  = route_port;
          state_d = R_SEND;
`ifdef SWITCH_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      R_SEND: begin
        vld = ONE_HOT0 << port_q;
        if (rdy_i[port_q]) begin
          pop     = 1'b1;
          state_d = R_IDLE;
        end
`ifdef SWITCH_SCHED_TIMEOUT_EN
        else if (tmo_q == 16'(TIMEOUT - 1)) begin
          pop     = 1'b1;
          err_d   = 1'b1;
          state_d = R_IDLE;
        end else begin
          tmo_d   = tmo_q + 16'd1;
        end
`endif
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign vld_o      = a_rst ? '0 : vld;
  assign mem_readed = pop & ~a_rst;
  assign out_port   = 32'(port_q);
  assign err_o      = err_q;

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (a_rst) begin
      rr_ptr_q <= '0;
      state_q  <= R_IDLE;
      port_q   <= '0;
      err_q    <= 1'b0;
`ifdef SWITCH_SCHED_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      rr_ptr_q <= rr_ptr_d;
      state_q  <= state_d;
      port_q   <= port_d;
      err_q    <= err_d;
`ifdef SWITCH_SCHED_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_switch_sched.sv
// tb/tb_switch_sched.sv - randomized self-checking bench for switch_sched (router at node 4 of a 3x3 mesh)
module tb_switch_sched;
  localparam int NP = 5;
`ifdef SWITCH_SCHED_TIMEOUT_EN
  localparam int BP_STALL = 5;
`else
  localparam int BP_STALL = 10;
`endif

  logic        clk = 1'b0;
  logic        a_rst;
  logic [4:0]  req_i, rdy_i, ack_o, vld_o;
  logic        mem_full, mem_empty, wr_req, mem_readed, err_o;
  logic [3:0]  head_addr;
  logic [31:0] in_port, out_port;

  int checks   = 0;
  int failures = 0;
  int mptr     = 0;
  bit merr     = 1'b0;

  always #5 clk = ~clk;

  switch_sched #(
    .ADDR_SIZE(4), .PORTS_NUM(4), .NODES_NUM(9), .MESH_X(3), .ADDR(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .a_rst(a_rst), .req_i(req_i), .ack_o(ack_o), .rdy_i(rdy_i), .vld_o(vld_o),
    .mem_full(mem_full), .mem_empty(mem_empty), .head_addr(head_addr), .wr_req(wr_req),
    .mem_readed(mem_readed), .in_port(in_port), .out_port(out_port), .err_o(err_o)
  );

  // Requester closest to the pointer going forward around the ring; -1 when none
  function automatic int model_grant(int ptr, logic [4:0] req);
    int best  = -1;
    int bestd = NP;
    for (int i = 0; i < NP; i++) begin
      if (req[i]) begin
        int d = (i - ptr + NP) % NP;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  // XY routing from node 4 at (1,1): 0=N 1=E 2=S 3=W 4=local
  function automatic int model_route(int a);
    int dx = (a % 3) - 1;
    int dy = (a / 3) - 1;
    if (dx > 0) return 1;
    if (dx < 0) return 3;
    if (dy > 0) return 2;
    if (dy < 0) return 0;
    return 4;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; req_i = 5'h1F; rdy_i = '0; mem_full = 1'b0; mem_empty = 1'b1; head_addr = '0;
    step; step;
    checks++; if (ack_o !== 5'b0 || wr_req !== 1'b0) begin failures++;
      $display("FAIL reset_write ack_o=%b wr_req=%b expected 00000/0", ack_o, wr_req); end
    checks++; if (vld_o !== 5'b0 || mem_readed !== 1'b0) begin failures++;
      $display("FAIL reset_read vld_o=%b mem_readed=%b expected 00000/0", vld_o, mem_readed); end
    checks++; if (err_o !== 1'b0 || out_port !== 32'd0) begin failures++;
      $display("FAIL reset_regs err_o=%b out_port=%0d expected 0/0", err_o, out_port); end
    a_rst = 1'b0; #1;
    mptr = 0; merr = 1'b0;
    checks++; if (ack_o !== 5'b00001 || wr_req !== 1'b1) begin failures++;
      $display("FAIL reset_first_grant ack_o=%b wr_req=%b expected 00001/1", ack_o, wr_req); end
    req_i = '0; #1;
    step;
  endtask

  task automatic test_round_robin;
    int seq [6] = '{0, 1, 4, 0, 1, 4};
    int g;
    bit exp_wr;
    logic [4:0] exp_ack;
    req_i = 5'b10011; mem_full = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_ack = 5'(1 << seq[c]);
      checks++; if (ack_o !== exp_ack || in_port !== 32'(seq[c])) begin failures++;
        $display("FAIL rr_directed[%0d] ack_o=%b in_port=%0d expected %b/%0d", c, ack_o, in_port, exp_ack, seq[c]); end
      mptr = (seq[c] + 1) % NP;
      step;
    end
    for (int c = 0; c < 60; c++) begin
      req_i    = 5'($urandom);
      mem_full = ($urandom_range(0, 3) == 0);
      #1;
      g       = model_grant(mptr, req_i);
      exp_wr  = (g >= 0) && !mem_full;
      exp_ack = exp_wr ? 5'(1 << g) : 5'b0;
      checks++; if (wr_req !== exp_wr || ack_o !== exp_ack) begin failures++;
        $display("FAIL rr_random[%0d] req=%b full=%b ack_o=%b wr_req=%b expected %b/%b", c, req_i, mem_full, ack_o, wr_req, exp_ack, exp_wr); end
      if (exp_wr) begin
        checks++; if (in_port !== 32'(g)) begin failures++;
          $display("FAIL rr_in_port[%0d] in_port=%0d expected %0d", c, in_port, g); end
        mptr = (g + 1) % NP;
      end
      step;
    end
    req_i = '0; mem_full = 1'b0; #1;
    step;
  endtask

  task automatic test_full;
    req_i = 5'b00100; mem_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (ack_o !== 5'b0 || wr_req !== 1'b0) begin failures++;
        $display("FAIL full_block[%0d] ack_o=%b wr_req=%b expected 00000/0", c, ack_o, wr_req); end
      step;
    end
    mem_full = 1'b0; #1;
    checks++; if (ack_o !== 5'b00100 || wr_req !== 1'b1) begin failures++;
      $display("FAIL full_release ack_o=%b wr_req=%b expected 00100/1", ack_o, wr_req); end
    mptr = 3;
    req_i = '0; #1;
    step;
  endtask

  task automatic test_routing;
    int dir_a [5] = '{5, 3, 1, 7, 4};
    int a, p, st;
    logic [4:0] oh;
    for (int n = 0; n < 15; n++) begin
      a  = (n < 5) ? dir_a[n] : int'($urandom_range(0, 8));
      st = (n == 0) ? BP_STALL : int'($urandom_range(0, 4));
      p  = model_route(a);
      oh = 5'(1 << p);
      head_addr = 4'(a); mem_empty = 1'b0; rdy_i = 5'($urandom) & ~oh; #1;
      checks++; if (vld_o !== 5'b0 || mem_readed !== 1'b0) begin failures++;
        $display("FAIL route_idle[%0d] vld_o=%b mem_readed=%b expected 00000/0", n, vld_o, mem_readed); end
      step;
      checks++; if (vld_o !== 5'b0 || mem_readed !== 1'b0) begin failures++;
        $display("FAIL route_latency[%0d] vld_o=%b mem_readed=%b expected 00000/0", n, vld_o, mem_readed); end
      step;
      for (int s = 0; s < st; s++) begin
        checks++; if (vld_o !== oh || out_port !== 32'(p) || mem_readed !== 1'b0) begin failures++;
          $display("FAIL route_stall[%0d.%0d] addr=%0d vld_o=%b out_port=%0d pop=%b expected %b/%0d/0", n, s, a, vld_o, out_port, mem_readed, oh, p); end
        step;
        rdy_i = 5'($urandom) & ~oh; #1;
      end
      rdy_i = 5'($urandom) | oh; #1;
      checks++; if (vld_o !== oh || out_port !== 32'(p) || mem_readed !== 1'b1) begin failures++;
        $display("FAIL route_send[%0d] addr=%0d vld_o=%b out_port=%0d pop=%b expected %b/%0d/1", n, a, vld_o, out_port, mem_readed, oh, p); end
      mem_empty = 1'b1;
      step;
      checks++; if (vld_o !== 5'b0 || mem_readed !== 1'b0) begin failures++;
        $display("FAIL route_done[%0d] vld_o=%b mem_readed=%b expected 00000/0", n, vld_o, mem_readed); end
    end
    rdy_i = '0;
  endtask

`ifdef SWITCH_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    head_addr = 4'd5; mem_empty = 1'b0; rdy_i = '0; #1;
    step; step;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (mem_readed !== (c == 8) || vld_o !== 5'b00010) begin failures++;
        $display("FAIL timeout_cycle[%0d] mem_readed=%b vld_o=%b expected %b/00010", c, mem_readed, vld_o, (c == 8)); end
      if (c == 8) mem_empty = 1'b1;
      step;
    end
    merr = 1'b1;
    checks++; if (err_o !== 1'b1 || vld_o !== 5'b0) begin failures++;
      $display("FAIL timeout_err err_o=%b vld_o=%b expected 1/00000", err_o, vld_o); end
  endtask
`endif

  task automatic test_bad_addr;
    head_addr = 4'd12; mem_empty = 1'b0; rdy_i = 5'h1F; #1;
    checks++; if (err_o !== merr) begin failures++;
      $display("FAIL bad_pre_err err_o=%b expected %b", err_o, merr); end
    step;
    checks++; if (mem_readed !== 1'b1 || vld_o !== 5'b0) begin failures++;
      $display("FAIL bad_drop mem_readed=%b vld_o=%b expected 1/00000", mem_readed, vld_o); end
    mem_empty = 1'b1;
    step;
    checks++; if (err_o !== 1'b1 || mem_readed !== 1'b0 || vld_o !== 5'b0) begin failures++;
      $display("FAIL bad_err err_o=%b pop=%b vld_o=%b expected 1/0/00000", err_o, mem_readed, vld_o); end
    repeat (5) step;
    checks++; if (err_o !== 1'b1) begin failures++;
      $display("FAIL bad_sticky err_o=%b expected 1", err_o); end
    a_rst = 1'b1;
    step;
    a_rst = 1'b0; #1;
    checks++; if (err_o !== 1'b0) begin failures++;
      $display("FAIL bad_reset_clear err_o=%b expected 0", err_o); end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_full;
    test_routing;
`ifdef SWITCH_SCHED_TIMEOUT_EN
    test_timeout;
`endif
    test_bad_addr;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
